// File: rtl/memory_controller.sv
// memory_controller: arbitrates instruction fetch and load/store buffer requests
// onto a byte-wide RAM/IO bus, splitting 1/2/4-byte accesses into little-endian
// byte transfers and returning assembled data with one-cycle done pulses.
module memory_controller #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR_MASK = 32'h00030000,
  parameter logic [2:0]            IF_WIDTH     = 3'd4
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  RoBMC_pre_judge,
  input  logic                  IFMC_en,
  input  logic [ADDR_WIDTH-1:0] IFMC_addr,
  output logic                  MCIF_en,
  output logic [31:0]           MCIF_data,
  input  logic                  LSBMC_en,
  input  logic                  LSBMC_wr,
  input  logic [2:0]            LSBMC_data_width,
  input  logic [31:0]           LSBMC_data,
  input  logic [ADDR_WIDTH-1:0] LSBMC_addr,
  output logic                  MCLSB_r_en,
  output logic                  MCLSB_w_en,
  output logic [31:0]           MCLSB_data,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [2:0]            len_q, len_d;
  logic                  owner_lsb_q, owner_lsb_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           buf_q, buf_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            dout_q, dout_d;
  logic                  wr_q, wr_d;
  logic                  if_en_q, if_en_d;
  logic                  r_en_q, r_en_d;
  logic                  w_en_q, w_en_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           lsb_data_q, lsb_data_d;

  logic [31:0]           buf_cap;
  logic [2:0]            lsb_len;
  logic                  last_byte;
  logic                  io_blocked;

  // Buffer with the byte currently on mem_din merged into the slot for cnt_q.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cap
    assign buf_cap[8*gi +: 8] = (cnt_q == 2'(gi)) ? mem_din : buf_q[8*gi +: 8];
  end

  assign last_byte  = ({1'b0, cnt_q} == (len_q - 3'd1));
  assign io_blocked = ((addr_q & IO_ADDR_MASK) == IO_ADDR_MASK) && io_buffer_full;

  assign mem_a      = addr_q;
  assign mem_dout   = dout_q;
  assign mem_wr     = wr_q && Sys_rdy && !io_blocked;
  assign MCIF_en    = if_en_q;
  assign MCIF_data  = if_data_q;
  assign MCLSB_r_en = r_en_q;
  assign MCLSB_w_en = w_en_q;
  assign MCLSB_data = lsb_data_q;

  // Map the requested LSB width to a byte count; anything unusual is a word.
  always_comb begin
    case (LSBMC_data_width)
      3'd1:    lsb_len = 3'd1;
      3'd2:    lsb_len = 3'd2;
      default: lsb_len = 3'd4;
    endcase
  end

  // Next-state logic: accept, byte sequencing, flush abort and done pulses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    owner_lsb_d = owner_lsb_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    wr_d        = wr_q;
    if_en_d     = if_en_q;
    r_en_d      = r_en_q;
    w_en_d      = w_en_q;
    if_data_d   = if_data_q;
    lsb_data_d  = lsb_data_q;
    if (Sys_rdy) begin
      case (state_q)
        S_IDLE: begin
          if (RoBMC_pre_judge && LSBMC_en) begin
            owner_lsb_d = 1'b1;
            len_d       = lsb_len;
            addr_d      = LSBMC_addr;
            wdata_d     = LSBMC_data;
            dout_d      = LSBMC_data[7:0];
            cnt_d       = 2'd0;
            buf_d       = 32'h0;
            wr_d        = LSBMC_wr;
            state_d     = LSBMC_wr ? S_WRITE : S_READ;
          end else if (RoBMC_pre_judge && IFMC_en) begin
            owner_lsb_d = 1'b0;
            len_d       = IF_WIDTH;
            addr_d      = IFMC_addr;
            cnt_d       = 2'd0;
            buf_d       = 32'h0;
            wr_d        = 1'b0;
            state_d     = S_READ;
          end
        end
        S_READ: begin
          if (!RoBMC_pre_judge) begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
            buf_d   = 32'h0;
          end else if (last_byte) begin
            buf_d   = buf_cap;
            cnt_d   = 2'd0;
            state_d = S_DONE;
            if (owner_lsb_q) begin
              r_en_d     = 1'b1;
              lsb_data_d = buf_cap;
            end else begin
              if_en_d   = 1'b1;
              if_data_d = buf_cap;
            end
          end else begin
            buf_d  = buf_cap;
            cnt_d  = cnt_q + 2'd1;
            addr_d = addr_q + 1'b1;
          end
        end
        S_WRITE: begin
          // Stores are already committed, so a flush does not stop them.
          if (!io_blocked) begin
            if (last_byte) begin
              wr_d    = 1'b0;
              cnt_d   = 2'd0;
              w_en_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              cnt_d   = cnt_q + 2'd1;
              addr_d  = addr_q + 1'b1;
              dout_d  = wdata_q[15:8];
              wdata_d = {8'h00, wdata_q[31:8]};
            end
          end
        end
        default: begin
          if_en_d = 1'b0;
          r_en_d  = 1'b0;
          w_en_d  = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers; reset drops everything, including any half-done write.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      len_q       <= 3'd0;
      owner_lsb_q <= 1'b0;
      wdata_q     <= 32'h0;
      buf_q       <= 32'h0;
      addr_q      <= '0;
      dout_q      <= 8'h0;
      wr_q        <= 1'b0;
      if_en_q     <= 1'b0;
      r_en_q      <= 1'b0;
      w_en_q      <= 1'b0;
      if_data_q   <= 32'h0;
      lsb_data_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      owner_lsb_q <= owner_lsb_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      wr_q        <= wr_d;
      if_en_q     <= if_en_d;
      r_en_q      <= r_en_d;
      w_en_q      <= w_en_d;
      if_data_q   <= if_data_d;
      lsb_data_q  <= lsb_data_d;
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: a byte RAM model, a write log and a
// response scoreboard checked when done pulses appear.
module tb_memory_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        pre_judge;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mcif_en;
  logic [31:0] mcif_data;
  logic        lsb_req;
  logic        lsb_wr;
  logic [2:0]  lsb_width;
  logic [31:0] lsb_data;
  logic [31:0] lsb_addr;
  logic        r_en;
  logic        w_en;
  logic [31:0] mclsb_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_full;

  localparam logic [2:0] K_IF = 3'b100;
  localparam logic [2:0] K_LD = 3'b010;
  localparam logic [2:0] K_ST = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q[$];
  logic [39:0] wlog[$];
  logic [7:0]  ram[0:4095];
  int          checks = 0;
  int          errors = 0;

  memory_controller dut (
    .Sys_clk(clk), .Sys_rst(rst), .Sys_rdy(rdy), .RoBMC_pre_judge(pre_judge),
    .IFMC_en(if_req), .IFMC_addr(if_addr), .MCIF_en(mcif_en), .MCIF_data(mcif_data),
    .LSBMC_en(lsb_req), .LSBMC_wr(lsb_wr), .LSBMC_data_width(lsb_width),
    .LSBMC_data(lsb_data), .LSBMC_addr(lsb_addr), .MCLSB_r_en(r_en),
    .MCLSB_w_en(w_en), .MCLSB_data(mclsb_data), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_full)
  );

  always #5 clk = ~clk;

  // RAM returns the byte at the registered address within the same cycle.
  assign mem_din = ram[mem_a[11:0]];

  always @(posedge clk) begin
    if (mem_wr) begin
      wlog.push_back({mem_a, mem_dout});
      if (mem_a[31:16] == 16'h0) ram[mem_a[11:0]] <= mem_dout;
    end
  end

  function automatic logic [31:0] ram_word(int a, int n);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = ram[(a + i) & 4095];
    return w;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(logic [2:0] kind, logic [31:0] data);
    resp_t r;
    r.kind = kind;
    r.data = data;
    exp_q.push_back(r);
  endtask

  task automatic lsb_issue(logic wr, logic [2:0] width, logic [31:0] data, logic [31:0] addr);
    lsb_req   = 1'b1;
    lsb_wr    = wr;
    lsb_width = width;
    lsb_data  = data;
    lsb_addr  = addr;
  endtask

  // Wait for the next done pulse, pop the scoreboard and compare; then confirm
  // the pulse lasts one cycle. cyc returns the negedges waited.
  task automatic wait_resp(string tag, output int cyc);
    resp_t       e;
    logic [2:0]  pul;
    bit          got = 1'b0;
    cyc = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mcif_en || r_en || w_en) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no pulse expected=done pulse", tag);
      lsb_req = 1'b0;
      if_req  = 1'b0;
      return;
    end
    pul = {mcif_en, r_en, w_en};
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_unexpected observed=pulse 0x%0h expected=none", tag, pul);
      return;
    end
    e = exp_q.pop_front();
    $display("resp %s kind=%b if_data=%h lsb_data=%h after %0d cycles", tag, pul, mcif_data, mclsb_data, cyc);
    check({tag, "_kind"}, 64'(pul), 64'(e.kind));
    if (e.kind == K_IF) check({tag, "_ifdata"}, 64'(mcif_data), 64'(e.data));
    if (e.kind == K_LD) check({tag, "_lddata"}, 64'(mclsb_data), 64'(e.data));
    if (pul[2]) if_req = 1'b0;
    else        lsb_req = 1'b0;
    @(negedge clk);
    check({tag, "_pulse1"}, 64'({mcif_en, r_en, w_en}), 64'(3'b000));
  endtask

  initial begin
    int  cyc;
    bit  seen;
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 7 + 3);
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    ram[12'h104] = 8'h55; ram[12'h105] = 8'h66; ram[12'h106] = 8'h77; ram[12'h107] = 8'h88;
    ram[12'h010] = 8'h80;

    rst = 1'b1; rdy = 1'b1; pre_judge = 1'b1; io_full = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_width = 3'd4; lsb_data = 32'h0; lsb_addr = 32'h0;

    // Reset state
    #3;
    check("rst_outs", 64'({mcif_en, r_en, w_en, mem_wr}), 64'(4'b0000));
    check("rst_mem_a", 64'(mem_a), 64'h0);
    check("rst_data", 64'({mcif_data, mclsb_data}), 64'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // lw @0x100: four consecutive addresses then a pulse right after E4
    push(K_LD, 32'h44332211);
    lsb_issue(1'b0, 3'd4, 32'h0, 32'h100);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("lw_a%0d", k), 64'(mem_a), 64'(32'h100 + k));
      check($sformatf("lw_nopulse%0d", k), 64'(r_en), 64'h0);
    end
    wait_resp("lw", cyc);
    check("lw_latency", 64'(cyc), 64'd1);

    // sh @0x202: two byte writes, one store pulse, no fetch pulse
    wlog.delete();
    push(K_ST, 32'h0);
    lsb_issue(1'b1, 3'd2, 32'hDEADBEEF, 32'h202);
    wait_resp("sh", cyc);
    check("sh_nwrites", 64'(wlog.size()), 64'd2);
    check("sh_w0", 64'(wlog[0]), 64'({32'h202, 8'hEF}));
    check("sh_w1", 64'(wlog[1]), 64'({32'h203, 8'hBE}));

    // Simultaneous fetch and lb: LSB first, fetch follows after DONE+IDLE
    push(K_LD, 32'h00000080);
    push(K_IF, ram_word(0, 4));
    if_req = 1'b1; if_addr = 32'h0;
    lsb_issue(1'b0, 3'd1, 32'h0, 32'h10);
    wait_resp("arb_lb", cyc);
    wait_resp("arb_if", cyc);
    check("arb_if_gap", 64'(cyc), 64'd5);

    // lh with a two-cycle Sys_rdy stall after the address is out
    push(K_LD, 32'h00002211);
    lsb_issue(1'b0, 3'd2, 32'h0, 32'h100);
    @(negedge clk); rdy = 1'b0;
    @(negedge clk);
    check("stall_wr", 64'(mem_wr), 64'h0);
    @(negedge clk); rdy = 1'b1;
    wait_resp("lh_stall", cyc);

    // Width 3 behaves as a word
    push(K_LD, 32'h44332211);
    lsb_issue(1'b0, 3'd3, 32'h0, 32'h100);
    wait_resp("w3", cyc);

    // sb to IO with the sink full for three cycles
    wlog.delete();
    io_full = 1'b1;
    push(K_ST, 32'h0);
    lsb_issue(1'b1, 3'd1, 32'h00000041, 32'h00030000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("io_hold%0d", k), 64'({mem_wr, mem_a}), 64'({1'b0, 32'h00030000}));
    end
    io_full = 1'b0;
    wait_resp("io_sb", cyc);
    check("io_nwrites", 64'(wlog.size()), 64'd1);
    check("io_w0", 64'(wlog[0]), 64'({32'h00030000, 8'h41}));

    // Fetch @0x40 flushed after two bytes: no pulse, then fetch @0x80 is clean
    if_req = 1'b1; if_addr = 32'h40;
    repeat (3) @(negedge clk);
    pre_judge = 1'b0; if_req = 1'b0;
    @(negedge clk); pre_judge = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= mcif_en;
    end
    check("flush_nopulse", 64'(seen), 64'h0);
    push(K_IF, ram_word(32'h80, 4));
    if_req = 1'b1; if_addr = 32'h80;
    wait_resp("if80", cyc);

    // sw @0x300 with a flush mid-way: all four bytes still written
    wlog.delete();
    push(K_ST, 32'h0);
    lsb_issue(1'b1, 3'd4, 32'hCAFEF00D, 32'h300);
    repeat (2) @(negedge clk);
    pre_judge = 1'b0;
    @(negedge clk); pre_judge = 1'b1;
    wait_resp("sw_flush", cyc);
    check("sw_nwrites", 64'(wlog.size()), 64'd4);
    check("sw_ram", 64'(ram_word(32'h300, 4)), 64'h00000000CAFEF00D);

    // Asynchronous reset in the middle of a lw, then a fresh lw
    lsb_issue(1'b0, 3'd4, 32'h0, 32'h104);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ctl", 64'({mcif_en, r_en, w_en, mem_wr}), 64'(4'b0000));
    check("arst_mem_a", 64'(mem_a), 64'h0);
    check("arst_data", 64'({mcif_data, mclsb_data}), 64'h0);
    lsb_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    push(K_LD, 32'h88776655);
    lsb_issue(1'b0, 3'd4, 32'h0, 32'h104);
    wait_resp("lw_after_rst", cyc);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
